pr_sel_arbiter: RTL and testbench

Round-robin arbiter that drives the 2-bit select of the 8-bit 4:1 priority-mux stage (`pr_en`) and sits directly upstream of it. Four requesters raise `req`; the arbiter grants one at a time, drives `sel` to steer that requester's byte through the mux, and handshakes each beat with the downstream consumer via `out_valid`/`out_ready`. Each grant lasts a bounded burst, then priority rotates so no channel starves.

---
 rtl/pr_sel_pkg.sv | 17 +
 rtl/pr_sel_arbiter_rr_pick.sv | 29 ++
 rtl/pr_sel_arbiter.sv | 123 ++++++++++++
 tb/tb_pr_sel_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pr_sel_pkg.sv
// Shared types and helpers for the round-robin select arbiter in front of the
// 8-bit 4:1 priority mux.
package pr_sel_pkg;

   localparam int NUM_CH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Next channel after p, wrapping modulo NUM_CH.
   function automatic logic [1:0] rr_next(input logic [1:0] p);
      return p + 2'd1;
   endfunction

endpackage

// File: rtl/pr_sel_arbiter_rr_pick.sv
// Rotating-priority pick: first set request bit found searching ptr, ptr+1, ...
// modulo four.
module rr_pick
   import pr_sel_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic       any,
   output logic [1:0] idx,
   output logic [3:0] onehot
);

   logic [1:0] cand;

   // Walk from the farthest candidate back to ptr so the nearest hit wins.
   always_comb begin
      any    = 1'b0;
      idx    = 2'd0;
      onehot = 4'b0000;
      cand   = 2'd0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         cand = ptr + 2'(k);
         any  = req[cand] ? 1'b1 : any;
         idx  = req[cand] ? cand : idx;
      end
      onehot = any ? (4'b0001 << idx) : 4'b0000;
   end

endmodule

// File: rtl/pr_sel_arbiter.sv
// Round-robin burst arbiter driving the select of the 4:1 byte mux, with a
// valid/ready beat handshake and zero-bubble handover between owners.
module pr_sel_arbiter
   import pr_sel_pkg::*;
#(
   parameter int unsigned BURST_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       out_ready,
   output logic [1:0] sel,
   output logic [3:0] gnt,
   output logic       out_valid,
   output logic [3:0] ack
);

   localparam int CW = $clog2(BURST_MAX + 1);
   localparam logic [CW-1:0] CNT_LIM = CW'(BURST_MAX);

   state_t        state_r, state_nx;
   logic [1:0]    owner_r, owner_nx;
   logic [1:0]    ptr_r, ptr_nx;
   logic [1:0]    sel_r, sel_nx;
   logic [3:0]    gnt_r, gnt_nx;
   logic [CW-1:0] cnt_r, cnt_nx;

   logic [1:0] pick_ptr_s;
   logic [1:0] pick_idx_s;
   logic [3:0] pick_oh_s;
   logic       pick_any_s;
   logic       owner_req_s;
   logic       beat_s;
   logic       last_beat_s;
   logic       grant_end_s;

   assign owner_req_s = req[owner_r];
   assign out_valid   = (state_r == GRANT) & owner_req_s;
   assign beat_s      = out_valid & out_ready;
   assign last_beat_s = beat_s & ((cnt_r + CW'(1)) == CNT_LIM);
   assign grant_end_s = (state_r == GRANT) & (~owner_req_s | last_beat_s);
   assign ack         = gnt_r & {4{beat_s}};
   assign sel         = sel_r;
   assign gnt         = gnt_r;

   // During a grant the pick is only consumed at grant end, so it can always
   // search from the channel after the current owner.
   assign pick_ptr_s = (state_r == GRANT) ? rr_next(owner_r) : ptr_r;

   rr_pick u_pick (
      .req    (req),
      .ptr    (pick_ptr_s),
      .any    (pick_any_s),
      .idx    (pick_idx_s),
      .onehot (pick_oh_s)
   );

   // Next-state and next-output decisions for the IDLE/GRANT machine.
   always_comb begin
      state_nx = state_r;
      owner_nx = owner_r;
      ptr_nx   = ptr_r;
      sel_nx   = sel_r;
      gnt_nx   = gnt_r;
      cnt_nx   = cnt_r;
      case (state_r)
         IDLE: begin
            gnt_nx = 4'b0000;
            if (pick_any_s) begin
               state_nx = GRANT;
               owner_nx = pick_idx_s;
               sel_nx   = pick_idx_s;
               gnt_nx   = pick_oh_s;
               cnt_nx   = '0;
            end else begin
               state_nx = IDLE;
            end
         end
         GRANT: begin
            if (grant_end_s) begin
               ptr_nx = rr_next(owner_r);
               if (pick_any_s) begin
                  owner_nx = pick_idx_s;
                  sel_nx   = pick_idx_s;
                  gnt_nx   = pick_oh_s;
                  cnt_nx   = '0;
               end else begin
                  state_nx = IDLE;
                  gnt_nx   = 4'b0000;
               end
            end else if (beat_s) begin
               cnt_nx = cnt_r + CW'(1);
            end else begin
               cnt_nx = cnt_r;
            end
         end
         default: begin
            state_nx = IDLE;
            gnt_nx   = 4'b0000;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         owner_r <= 2'd0;
         ptr_r   <= 2'd0;
         sel_r   <= 2'd0;
         gnt_r   <= 4'b0000;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nx;
         owner_r <= owner_nx;
         ptr_r   <= ptr_nx;
         sel_r   <= sel_nx;
         gnt_r   <= gnt_nx;
         cnt_r   <= cnt_nx;
      end
   end

endmodule

// File: tb/tb_pr_sel_arbiter.sv
// Bench for pr_sel_arbiter: three instances (BURST_MAX 4, 2, 1) share stimulus
// and are compared every cycle against a behavioural round-robin model.
module tb_pr_sel_arbiter;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       out_ready;

   logic [1:0] sel_a   [NI];
   logic [3:0] gnt_a   [NI];
   logic       valid_a [NI];
   logic [3:0] ack_a   [NI];

   bit m_busy  [NI];
   int m_owner [NI];
   int m_ptr   [NI];
   int m_cnt   [NI];
   int m_sel   [NI];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pr_sel_arbiter #(.BURST_MAX(4)) u_b4 (
      .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
      .sel(sel_a[0]), .gnt(gnt_a[0]), .out_valid(valid_a[0]), .ack(ack_a[0])
   );
   pr_sel_arbiter #(.BURST_MAX(2)) u_b2 (
      .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
      .sel(sel_a[1]), .gnt(gnt_a[1]), .out_valid(valid_a[1]), .ack(ack_a[1])
   );
   pr_sel_arbiter #(.BURST_MAX(1)) u_b1 (
      .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
      .sel(sel_a[2]), .gnt(gnt_a[2]), .out_valid(valid_a[2]), .ack(ack_a[2])
   );

   function automatic int burst_of(input int i);
      case (i)
         0:       return 4;
         1:       return 2;
         default: return 1;
      endcase
   endfunction

   // First requesting channel at or after p, wrapping; -1 if none.
   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_busy[i]  = 1'b0;
         m_owner[i] = 0;
         m_ptr[i]   = 0;
         m_cnt[i]   = 0;
         m_sel[i]   = 0;
      end
   endtask

   // Advance the model by one rising edge using the current req/out_ready.
   task automatic model_step();
      int  p;
      bit  done;
      for (int i = 0; i < NI; i++) begin
         done = 1'b0;
         if (!m_busy[i]) begin
            p = pick(req, m_ptr[i]);
            if (p >= 0) begin
               m_busy[i]  = 1'b1;
               m_owner[i] = p;
               m_sel[i]   = p;
               m_cnt[i]   = 0;
            end
         end else begin
            if (!req[m_owner[i]]) begin
               done = 1'b1;
            end else if (out_ready) begin
               m_cnt[i]++;
               if (m_cnt[i] == burst_of(i)) done = 1'b1;
            end
            if (done) begin
               m_ptr[i] = (m_owner[i] + 1) % 4;
               p = pick(req, m_ptr[i]);
               if (p >= 0) begin
                  m_owner[i] = p;
                  m_sel[i]   = p;
                  m_cnt[i]   = 0;
               end else begin
                  m_busy[i] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic check_all(input string sect);
      logic [3:0] e_gnt;
      logic       e_valid;
      for (int i = 0; i < NI; i++) begin
         e_gnt   = m_busy[i] ? 4'(1 << m_owner[i]) : 4'b0000;
         e_valid = m_busy[i] && req[m_owner[i]];
         check_val($sformatf("%s/b%0d gnt", sect, burst_of(i)), 32'(gnt_a[i]), 32'(e_gnt));
         check_val($sformatf("%s/b%0d sel", sect, burst_of(i)), 32'(sel_a[i]), 32'(m_sel[i]));
         check_val($sformatf("%s/b%0d valid", sect, burst_of(i)), 32'(valid_a[i]), 32'(e_valid));
         check_val($sformatf("%s/b%0d ack", sect, burst_of(i)), 32'(ack_a[i]),
                   32'((e_valid && out_ready) ? e_gnt : 4'b0000));
      end
   endtask

   task automatic cycle(input logic [3:0] r, input logic rdy, input string sect);
      @(negedge clk);
      req       = r;
      out_ready = rdy;
      #1;
      check_all(sect);
      @(posedge clk);
      model_step();
   endtask

   // Asynchronous reset between edges, release on a falling edge.
   task automatic mid_reset(input string sect);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      req   = 4'b0000;
      #1;
      model_reset();
      check_all(sect);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      model_step();
   endtask

   initial begin
      logic [3:0] r;
      rst_n     = 1'b0;
      req       = 4'b0000;
      out_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;
      @(posedge clk);
      model_step();

      // single requester on channel 2, then withdraw
      repeat (7) cycle(4'b0100, 1'b1, "single");
      repeat (3) cycle(4'b0000, 1'b1, "single_drop");

      // all requesting, full throughput rotation
      repeat (14) cycle(4'b1111, 1'b1, "all_req");
      repeat (2) cycle(4'b0000, 1'b1, "all_drop");

      // backpressure on owner 1
      cycle(4'b0010, 1'b0, "bp_grant");
      repeat (5) cycle(4'b0010, 1'b0, "bp_stall");
      repeat (5) cycle(4'b0010, 1'b1, "bp_resume");
      repeat (2) cycle(4'b0000, 1'b1, "bp_drop");

      // channel 3 withdraws mid-burst while channel 0 waits
      repeat (2) cycle(4'b1000, 1'b1, "wd_own3");
      cycle(4'b1001, 1'b1, "wd_both");
      repeat (3) cycle(4'b0001, 1'b1, "wd_to0");
      repeat (2) cycle(4'b0000, 1'b1, "wd_drop");

      // reset in the middle of a burst, then a fresh request from channel 1
      repeat (3) cycle(4'b1111, 1'b1, "rst_pre");
      mid_reset("rst_async");
      repeat (4) cycle(4'b0010, 1'b1, "rst_post");
      repeat (2) cycle(4'b0000, 1'b1, "rst_drop");

      // sole requester is re-granted continuously
      repeat (8) cycle(4'b0001, 1'b1, "sole");
      repeat (2) cycle(4'b0000, 1'b1, "sole_drop");

      // randomized traffic with sticky requests and random backpressure
      r = 4'b0000;
      for (int n = 0; n < 1500; n++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
         end
         cycle(r, ($urandom_range(0, 3) != 0), "rand");
         if (n == 700) mid_reset("rand_rst");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
